// File: rtl/brick_hit_tracker_pkg.sv
// Shared brick-row geometry, scan FSM states and small helpers for the brick
// hit tracker, the renderer and the power bar.
package brick_hit_tracker_pkg;

  localparam int unsigned N_BRICKS    = 13;
  localparam int unsigned BRICK_X0    = 8;
  localparam int unsigned BRICK_W     = 44;
  localparam int unsigned BRICK_PITCH = 48;
  localparam int unsigned BRICK_Y0    = 40;
  localparam int unsigned BRICK_H     = 16;
  localparam int unsigned BALL_SIZE   = 8;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } scan_state_t;

  function automatic logic [IDX_W-1:0] popcount(input logic [N_BRICKS-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_BRICKS; i++) begin
      c = c + {{(IDX_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/brick_hit_tracker_overlap.sv
// Combinational ball-vs-brick test: derives brick k's box from its index and
// checks inclusive-edge intersection with the ball box.
module brick_overlap
  import brick_hit_tracker_pkg::*;
#(
  parameter int unsigned X0    = BRICK_X0,
  parameter int unsigned W     = BRICK_W,
  parameter int unsigned PITCH = BRICK_PITCH,
  parameter int unsigned Y0    = BRICK_Y0,
  parameter int unsigned H     = BRICK_H,
  parameter int unsigned BALL  = BALL_SIZE
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [IDX_W-1:0]   brick_idx,
  output logic               overlap
);

  // 12-bit arithmetic keeps ball_x + BALL-1 from wrapping near 2047
  logic [11:0] left, right, top, bottom;
  logic [11:0] bx_lo, bx_hi, by_lo, by_hi;

  assign left   = 12'(X0) + 12'(brick_idx) * 12'(PITCH);
  assign right  = left + 12'(W - 1);
  assign top    = 12'(Y0);
  assign bottom = 12'(Y0 + H - 1);

  assign bx_lo = {1'b0, ball_x};
  assign bx_hi = bx_lo + 12'(BALL - 1);
  assign by_lo = {1'b0, ball_y};
  assign by_hi = by_lo + 12'(BALL - 1);

  assign overlap = (bx_lo <= right) && (bx_hi >= left) &&
                   (by_lo <= bottom) && (by_hi >= top);

endmodule

// File: rtl/brick_hit_tracker.sv
// Per-frame brick collision scanner: latches the ball at refr_tick, walks the
// bricks in index order and clears the first live overlapping one.
module brick_hit_tracker
  import brick_hit_tracker_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                refr_tick,
  input  logic                game_start,
  input  logic [COORD_W-1:0]  ball_x,
  input  logic [COORD_W-1:0]  ball_y,
  output logic [N_BRICKS-1:0] brick_alive,
  output logic [IDX_W-1:0]    bricks_left,
  output logic                all_cleared,
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx,
  output logic                scan_busy
);

  scan_state_t state, state_nxt;

  logic [IDX_W-1:0]    idx;
  logic [COORD_W-1:0]  lat_x, lat_y;
  logic [N_BRICKS-1:0] alive_nxt;
  logic                overlap;
  logic                last_idx;
  logic                clear_now;
  logic                start_scan;

  brick_overlap u_overlap (
    .ball_x    (lat_x),
    .ball_y    (lat_y),
    .brick_idx (idx),
    .overlap   (overlap)
  );

  assign last_idx   = (idx == IDX_W'(N_BRICKS - 1));
  assign clear_now  = (state == ST_SCAN) && brick_alive[idx] && overlap;
  assign start_scan = (state == ST_IDLE) && refr_tick && !game_start;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (refr_tick) state_nxt = ST_SCAN;
      ST_SCAN: if (clear_now || last_idx) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (game_start) state_nxt = ST_IDLE;
  end

  always_comb begin
    alive_nxt = brick_alive;
    if (game_start) begin
      alive_nxt = '1;
    end else if (clear_now) begin
      alive_nxt[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      brick_alive <= '1;
      bricks_left <= IDX_W'(N_BRICKS);
      hit         <= 1'b0;
      hit_idx     <= '0;
    end else begin
      state       <= state_nxt;
      brick_alive <= alive_nxt;
      // count follows the next alive vector so both move on the same edge
      bricks_left <= popcount(alive_nxt);
      hit         <= clear_now && !game_start;
      if (clear_now && !game_start) hit_idx <= idx;
      if (state == ST_IDLE && refr_tick) begin
        lat_x <= ball_x;
        lat_y <= ball_y;
        idx   <= '0;
      end else if (state == ST_SCAN && !clear_now && !last_idx) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign all_cleared = (bricks_left == '0);
  // busy also covers the accepting cycle, so a no-hit frame reads busy for N_BRICKS+2 cycles
  assign scan_busy   = (state != ST_IDLE) || (start_scan && !reset);

endmodule

// File: tb/tb_brick_hit_tracker.sv
// Self-checking bench for brick_hit_tracker: directed scenarios with literal
// expectations plus randomized frames checked every cycle against a frame-level model.
module tb_brick_hit_tracker;

  logic        clk = 1'b0;
  logic        reset, refr_tick, game_start;
  logic [10:0] ball_x, ball_y;
  logic [12:0] brick_alive;
  logic [3:0]  bricks_left;
  logic        all_cleared, hit, scan_busy;
  logic [3:0]  hit_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  brick_hit_tracker dut (
    .clk         (clk),
    .reset       (reset),
    .refr_tick   (refr_tick),
    .game_start  (game_start),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .brick_alive (brick_alive),
    .bricks_left (bricks_left),
    .all_cleared (all_cleared),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .scan_busy   (scan_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Lowest live brick whose box meets the ball box, or -1.
  function automatic int first_hit(input int x, input int y, input logic [12:0] alive);
    for (int k = 0; k < 13; k++) begin
      int l;
      l = 8 + 48 * k;
      if (alive[k] && x <= l + 43 && x + 7 >= l && y <= 55 && y + 7 >= 40) return k;
    end
    return -1;
  endfunction

  // Frame-level model: each accepted refr_tick fixes the winner and its timing up front.
  bit          m_valid = 0;
  bit          m_active;
  int          m_hit_cycle, m_end, m_k;
  logic [12:0] m_alive;
  logic [3:0]  m_hit_idx;

  always @(negedge clk) begin
    int k;
    if (m_valid && !reset) begin
      chk("brick_alive", brick_alive, m_alive);
      chk("bricks_left", bricks_left, $countones(m_alive));
      chk("all_cleared", all_cleared, m_alive == 13'h0);
      chk("hit", hit, m_active && cyc == m_hit_cycle);
      chk("hit_idx", hit_idx, m_hit_idx);
      chk("scan_busy", scan_busy, m_active || (refr_tick && !game_start));
    end
    if (reset) begin
      m_valid = 1; m_active = 0; m_alive = 13'h1FFF; m_hit_idx = 0; m_hit_cycle = -1;
    end else if (m_valid) begin
      if (game_start) begin
        m_alive = 13'h1FFF; m_active = 0;
      end else if (m_active) begin
        if (cyc + 1 == m_hit_cycle) begin
          m_alive[m_k] = 1'b0;
          m_hit_idx = 4'(m_k);
        end
        if (cyc == m_end) m_active = 0;
      end else if (refr_tick) begin
        k = first_hit(int'(ball_x), int'(ball_y), m_alive);
        m_active = 1;
        if (k >= 0) begin
          m_k = k; m_hit_cycle = cyc + 2 + k; m_end = m_hit_cycle;
        end else begin
          m_hit_cycle = -1; m_end = cyc + 14;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  // Raises refr_tick for one cycle; returns in cycle t+1.
  task automatic start_frame(input int x, input int y);
    ball_x = 11'(x); ball_y = 11'(y); refr_tick = 1;
    step();
    refr_tick = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!scan_busy) return;
      step();
    end
    chk("idle_timeout", 32'(scan_busy), 32'd0);
  endtask

  // Counts busy and hit cycles of one frame; optionally re-ticks mid-scan.
  task automatic frame_busy(input int x, input int y, input bit extra_tick,
                            output int n, output int hits);
    ball_x = 11'(x); ball_y = 11'(y); refr_tick = 1; n = 0; hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hit) hits++;
      if (!scan_busy) break;
      n++;
      @(posedge clk); #1;
      refr_tick = extra_tick && (i == 2);
    end
    refr_tick = 0;
    step();
  endtask

  initial begin
    int n, h;
    reset = 1; refr_tick = 0; game_start = 0; ball_x = '0; ball_y = '0;
    step(); step(); reset = 0;
    chk("rst_alive", brick_alive, 13'h1FFF);
    chk("rst_left", bricks_left, 4'd13);
    chk("rst_hit", hit, 1'b0);
    chk("rst_busy", scan_busy, 1'b0);

    start_frame(10, 44); step();
    chk("t2_hit", hit, 1'b1);
    chk("t2_idx", hit_idx, 4'd0);
    chk("t2_alive", brick_alive, 13'h1FFE);
    chk("t2_left", bricks_left, 4'd12);
    wait_idle();

    do_reset();
    start_frame(50, 44); step();
    chk("t3a_hit", hit, 1'b1);
    chk("t3a_alive", brick_alive, 13'h1FFE);
    wait_idle();
    start_frame(50, 44); step(); step();
    chk("t3b_hit", hit, 1'b1);
    chk("t3b_idx", hit_idx, 4'd1);
    chk("t3b_alive", brick_alive, 13'h1FFC);
    wait_idle();

    frame_busy(300, 200, 0, n, h);
    chk("t4_busy_cycles", n, 15);
    chk("t4_hits", h, 0);

    do_reset();
    start_frame(10, 44);
    game_start = 1; step(); game_start = 0;
    chk("t5_gs_hit", hit, 1'b0);
    chk("t5_gs_alive", brick_alive, 13'h1FFF);
    chk("t5_gs_busy", scan_busy, 1'b0);
    start_frame(8 + 48 * 3 + 10, 44); step(); step(); step(); step();
    chk("t5_idx3", hit_idx, 4'd3);
    chk("t5_alive3", brick_alive, 13'h1FF7);
    wait_idle();
    start_frame(300, 200); step(); step();
    reset = 1; step(); reset = 0;
    chk("t5_rst_alive", brick_alive, 13'h1FFF);
    chk("t5_rst_left", bricks_left, 4'd13);
    chk("t5_rst_idx", hit_idx, 4'd0);
    chk("t5_rst_busy", scan_busy, 1'b0);

    for (int k = 0; k < 13; k++) begin
      start_frame(8 + 48 * k + 10, 44);
      wait_idle();
    end
    chk("t6_left", bricks_left, 4'd0);
    chk("t6_cleared", all_cleared, 1'b1);
    frame_busy(10, 44, 1, n, h);
    chk("t6_busy_cycles", n, 15);
    chk("t6_hits", h, 0);

    game_start = 1; step(); game_start = 0;
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom % 600) == 0;
      game_start = ($urandom % 120) == 0;
      refr_tick  = ($urandom % 4) == 0;
      ball_x     = ($urandom % 10 < 7) ? 11'($urandom_range(0, 640)) : 11'($urandom);
      ball_y     = ($urandom % 10 < 6) ? 11'($urandom_range(28, 60)) : 11'($urandom);
      step();
    end
    reset = 0; game_start = 0; refr_tick = 0;
    for (int i = 0; i < 20; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
